// File: rtl/inst_memory_access_pkg.sv
// Shared MEM-stage definitions: FSM encodings, opcodes and register constants.
package inst_memory_access_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // A flushed bubble (all-zero word) never writes back.
    function automatic logic [4:0] wb_dest(input logic [31:0] inst, input logic [4:0] rd);
        return (inst == 32'd0) ? REG_ZERO : rd;
    endfunction

endpackage

// File: rtl/inst_memory_access_mem_wait_timer.sv
// Saturating count of un-acked bus cycles; flags when the next miss is the last allowed.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != 8'hff)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count >= LAST);

endmodule

// File: rtl/inst_memory_access.sv
// MEM stage: pass-through of ALU results and a stalling req/ack data-memory access for lw/sw.
//   state    | meaning
//   MEM_IDLE | accept next instruction; mem ops latch operands and raise the request
//   MEM_BUSY | request held on the bus until ack or timeout, upstream stalled
//   MEM_DONE | result presented to WB, upstream released
module inst_memory_access
    import inst_memory_access_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int ADDR_W   = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [31:0]       inst_in,
    input  logic              load_in,
    input  logic              store_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [4:0]        rd_in,
    input  logic [31:0]       rd_val_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic [4:0]        mem_rd,
    output logic [31:0]       mem_rd_val,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       inst_out,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_val,
    output logic              bus_err
);

    mem_state_e        state, state_nxt;
    logic              start, ack_hit, timeout, expired;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic [4:0]        rd_q;
    logic              is_load_q;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state != MEM_BUSY),
        .inc     ((state == MEM_BUSY) && !dmem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE: if (start) state_nxt = MEM_BUSY;
            MEM_BUSY: if (ack_hit || timeout) state_nxt = MEM_DONE;
            MEM_DONE: state_nxt = MEM_IDLE;
            default:  state_nxt = MEM_IDLE;
        endcase
    end

    // Stall is gated by reset so a held load_in cannot freeze upstream while in reset.
    always_comb begin
        start      = (state == MEM_IDLE) && (load_in || store_in);
        ack_hit    = (state == MEM_BUSY) && dmem_ack;
        timeout    = (state == MEM_BUSY) && !dmem_ack && expired;
        stall      = rst_n && (start || (state == MEM_BUSY));
        mem_rd     = (state == MEM_BUSY) ? REG_ZERO : wb_rd;
        mem_rd_val = ((state == MEM_BUSY) || (wb_rd == REG_ZERO)) ? 32'd0 : wb_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            inst_q     <= '0;
            rd_q       <= REG_ZERO;
            is_load_q  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            pc_out     <= '0;
            inst_out   <= '0;
            wb_rd      <= REG_ZERO;
            wb_val     <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (start) begin
                        pc_q       <= pc_in;
                        inst_q     <= inst_in;
                        rd_q       <= rd_in;
                        is_load_q  <= load_in && !store_in;
                        dmem_req   <= 1'b1;
                        dmem_we    <= store_in;
                        dmem_addr  <= addr_in;
                        dmem_wdata <= rd_val_in;
                    end else begin
                        pc_out   <= pc_in;
                        inst_out <= inst_in;
                        wb_rd    <= wb_dest(inst_in, rd_in);
                        wb_val   <= (wb_dest(inst_in, rd_in) == REG_ZERO) ? 32'd0 : rd_val_in;
                    end
                end
                MEM_BUSY: begin
                    if (ack_hit || timeout) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc_out   <= pc_q;
                        inst_out <= inst_q;
                        // A timed-out load still retires, writing 0 so the register is defined.
                        if (is_load_q) begin
                            wb_rd  <= rd_q;
                            wb_val <= (ack_hit && (rd_q != REG_ZERO)) ? dmem_rdata : 32'd0;
                        end else begin
                            wb_rd  <= REG_ZERO;
                            wb_val <= 32'd0;
                        end
                        if (timeout) bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_memory_access.sv
// Bench for the MEM stage: directed vector table, random instruction stream vs. a
// transaction-level memory model, and reset corner cases.
module tb_inst_memory_access;
    import inst_memory_access_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int ADDR_W   = 30;

    logic              clk, rst_n;
    logic [ADDR_W-1:0] pc_in, addr_in, dmem_addr, pc_out;
    logic [31:0]       inst_in, rd_val_in, dmem_wdata, dmem_rdata, mem_rd_val, inst_out, wb_val;
    logic              load_in, store_in, stall, dmem_req, dmem_we, dmem_ack, bus_err;
    logic [4:0]        rd_in, mem_rd, wb_rd;

    inst_memory_access #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in), .load_in(load_in),
        .store_in(store_in), .addr_in(addr_in), .rd_in(rd_in), .rd_val_in(rd_val_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_rd(mem_rd), .mem_rd_val(mem_rd_val), .pc_out(pc_out), .inst_out(inst_out),
        .wb_rd(wb_rd), .wb_val(wb_val), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [31:0] inst;
        logic [29:0] pc;
        logic [29:0] addr;
        logic [4:0]  rd;
        logic [31:0] val;
        int          waits;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        logic        chk_val;
        int          e_stall;
        logic        e_err;
    } vec_t;

    logic [31:0] slave_mem [512];
    logic [31:0] ref_mem   [512];
    logic        exp_err;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_inst(input logic [4:0] rd);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] mem_inst(input logic [5:0] op, input logic [4:0] rd);
        return {op, 5'd0, rd, 16'h0000};
    endfunction

    // Reference: what the stage should deliver for one instruction given the bus wait count.
    task automatic predict(input logic ld, input logic st, input logic [31:0] inst,
                           input logic [29:0] addr, input logic [4:0] rd, input logic [31:0] val,
                           input int waits, output logic [4:0] e_rd, output logic [31:0] e_val,
                           output logic chk, output int e_stall);
        bit to;
        to = (waits >= MAX_WAIT);
        if (!(ld || st)) begin
            e_stall = 0;
            e_rd    = (inst == 32'd0) ? 5'd0 : rd;
            e_val   = (inst == 32'd0 || rd == 5'd0) ? 32'd0 : val;
            chk     = (inst != 32'd0);
        end else begin
            e_stall = to ? MAX_WAIT + 1 : waits + 2;
            if (to) exp_err = 1'b1;
            if (st) begin
                e_rd  = 5'd0;
                e_val = 32'd0;
                chk   = 1'b0;
                if (!to) ref_mem[addr[8:0]] = val;
            end else begin
                e_rd  = rd;
                e_val = (to || rd == 5'd0) ? 32'd0 : ref_mem[addr[8:0]];
                chk   = 1'b1;
            end
        end
    endtask

    // Drives one instruction as a stall-respecting upstream while acting as the bus slave.
    task automatic run_inst(input logic ld, input logic st, input logic [31:0] inst,
                            input logic [29:0] pc, input logic [29:0] addr, input logic [4:0] rd,
                            input logic [31:0] val, input int waits, input string tag,
                            output logic [4:0] o_rd, output logic [31:0] o_val,
                            output logic [4:0] o_frd, output logic [31:0] o_fval,
                            output int o_stall, output logic o_err);
        int req_cnt, bad_hold, exp_req;
        bit released, mem_op;
        req_cnt  = 0;
        bad_hold = 0;
        released = 0;
        mem_op   = ld || st;
        load_in = ld; store_in = st; inst_in = inst; pc_in = pc;
        addr_in = addr; rd_in = rd; rd_val_in = val;
        o_stall = 0;
        for (int c = 0; c < 64; c++) begin
            if (dmem_req) begin
                if (req_cnt == waits) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = slave_mem[dmem_addr[8:0]];
                    if (dmem_we) slave_mem[dmem_addr[8:0]] = dmem_wdata;
                end else begin
                    dmem_ack   = 1'b0;
                    dmem_rdata = $urandom;
                end
            end else begin
                dmem_ack   = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            if (!stall) begin
                released = 1;
                break;
            end
            o_stall++;
            if (dmem_req) begin
                req_cnt++;
                if (dmem_addr !== addr || dmem_we !== st || dmem_wdata !== val ||
                    mem_rd !== 5'd0 || mem_rd_val !== 32'd0) bad_hold++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        exp_req = !mem_op ? 0 : ((waits >= MAX_WAIT) ? MAX_WAIT : waits + 1);
        check($sformatf("%s_released", tag), 64'(released), 64'd1);
        check($sformatf("%s_req_cycles", tag), 64'(req_cnt), 64'(exp_req));
        check($sformatf("%s_bus_hold", tag), 64'(bad_hold), 64'd0);
        if (!mem_op) begin
            @(posedge clk);
            @(negedge clk);
        end
        check($sformatf("%s_req_low", tag), 64'(dmem_req), 64'd0);
        check($sformatf("%s_pc_inst", tag), 64'({pc_out, inst_out}), 64'({pc, inst}));
        o_rd   = wb_rd;
        o_val  = wb_val;
        o_frd  = mem_rd;
        o_fval = mem_rd_val;
        o_err  = bus_err;
        if (mem_op) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic judge(input string tag, input logic [4:0] e_rd, input logic [31:0] e_val,
                         input logic chk, input int e_stall, input logic e_err,
                         input logic [4:0] o_rd, input logic [31:0] o_val,
                         input logic [4:0] o_frd, input logic [31:0] o_fval,
                         input int o_stall, input logic o_err);
        check($sformatf("%s_wb_rd", tag), 64'(o_rd), 64'(e_rd));
        check($sformatf("%s_mem_rd", tag), 64'(o_frd), 64'(e_rd));
        if (chk) begin
            check($sformatf("%s_wb_val", tag), 64'(o_val), 64'(e_val));
            check($sformatf("%s_mem_rd_val", tag), 64'(o_fval), 64'(e_val));
        end
        check($sformatf("%s_stall_cycles", tag), 64'(o_stall), 64'(e_stall));
        check($sformatf("%s_bus_err", tag), 64'(o_err), 64'(e_err));
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] inst,
                                input logic [29:0] pc, input logic [29:0] addr,
                                input logic [4:0] rd, input logic [31:0] val, input int waits,
                                input logic [4:0] e_rd, input logic [31:0] e_val,
                                input logic chk_val, input int e_stall, input logic e_err);
        return '{ld, st, inst, pc, addr, rd, val, waits, e_rd, e_val, chk_val, e_stall, e_err};
    endfunction

    initial begin
        vec_t        vecs [12];
        vec_t        v;
        logic [4:0]  e_rd, o_rd, o_frd;
        logic [31:0] e_val, o_val, o_fval, tmp;
        logic        chk, o_err, ld, st;
        logic [31:0] inst;
        logic [4:0]  rd;
        int          e_stall, o_stall, waits, kind;

        vecs[0]  = mk(0, 0, alu_inst(5'd5),      30'h10,  30'h0,   5'd5,  32'h1234,     0,   5'd5,  32'h1234,     1, 0,  0);
        vecs[1]  = mk(0, 0, alu_inst(5'd0),      30'h11,  30'h0,   5'd0,  32'hffff,     0,   5'd0,  32'h0,        1, 0,  0);
        vecs[2]  = mk(0, 0, 32'd0,               30'h12,  30'h0,   5'd7,  32'h77,       0,   5'd0,  32'h0,        0, 0,  0);
        vecs[3]  = mk(0, 1, mem_inst(OP_SW, 12), 30'h13,  30'h3,   5'd12, 32'hdeadbeef, 1,   5'd0,  32'h0,        0, 3,  0);
        vecs[4]  = mk(1, 0, mem_inst(OP_LW, 9),  30'h14,  30'h3,   5'd9,  32'h0,        0,   5'd9,  32'hdeadbeef, 1, 2,  0);
        vecs[5]  = mk(0, 1, mem_inst(OP_SW, 1),  30'h15,  30'h100, 5'd1,  32'h55aa,     4,   5'd0,  32'h0,        0, 6,  0);
        vecs[6]  = mk(1, 0, mem_inst(OP_LW, 4),  30'h16,  30'h100, 5'd4,  32'h0,        2,   5'd4,  32'h55aa,     1, 4,  0);
        vecs[7]  = mk(1, 1, mem_inst(OP_SW, 6),  30'h17,  30'h5,   5'd6,  32'habcd,     0,   5'd0,  32'h0,        0, 2,  0);
        vecs[8]  = mk(1, 0, mem_inst(OP_LW, 6),  30'h18,  30'h5,   5'd6,  32'h0,        3,   5'd6,  32'habcd,     1, 5,  0);
        vecs[9]  = mk(1, 0, mem_inst(OP_LW, 0),  30'h19,  30'h5,   5'd0,  32'h0,        0,   5'd0,  32'h0,        1, 2,  0);
        vecs[10] = mk(1, 0, mem_inst(OP_LW, 8),  30'h1a,  30'h3,   5'd8,  32'h0,        100, 5'd8,  32'h0,        1, 16, 1);
        vecs[11] = mk(0, 0, alu_inst(5'd10),     30'h1b,  30'h0,   5'd10, 32'h42,       0,   5'd10, 32'h42,       1, 0,  1);

        for (int i = 0; i < 512; i++) begin
            tmp = $urandom;
            slave_mem[i] = tmp;
            ref_mem[i]   = tmp;
        end
        exp_err = 1'b0;

        // Reset held while a load is presented: everything must stay quiet.
        rst_n = 1'b0; load_in = 1'b1; store_in = 1'b0; inst_in = mem_inst(OP_LW, 3);
        pc_in = 30'h3ff; addr_in = 30'h7; rd_in = 5'd3; rd_val_in = 32'hcafe;
        dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 64'(|{stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, mem_rd,
                                     mem_rd_val, pc_out, inst_out, wb_rd, wb_val, bus_err}), 64'd0);
        @(negedge clk);
        load_in = 1'b0;
        rst_n   = 1'b1;

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            predict(v.ld, v.st, v.inst, v.addr, v.rd, v.val, v.waits, e_rd, e_val, chk, e_stall);
            run_inst(v.ld, v.st, v.inst, v.pc, v.addr, v.rd, v.val, v.waits,
                     $sformatf("vec%0d", i), o_rd, o_val, o_frd, o_fval, o_stall, o_err);
            judge($sformatf("vec%0d", i), v.e_rd, v.e_val, v.chk_val, v.e_stall, v.e_err,
                  o_rd, o_val, o_frd, o_fval, o_stall, o_err);
        end

        for (int k = 0; k < 150; k++) begin
            kind  = $urandom_range(0, 9);
            rd    = 5'($urandom_range(0, 31));
            waits = $urandom_range(0, 5);
            if ($urandom_range(0, 24) == 0) waits = 100;
            ld = 1'b0; st = 1'b0; inst = alu_inst(rd);
            case (kind)
                3:       inst = 32'd0;
                4, 5:    begin ld = 1'b1; inst = mem_inst(OP_LW, rd); end
                6, 7:    begin st = 1'b1; inst = mem_inst(OP_SW, rd); end
                8:       begin ld = 1'b1; st = 1'b1; inst = mem_inst(OP_SW, rd); end
                9:       begin rd = 5'd0; inst = alu_inst(rd); end
                default: ;
            endcase
            v = mk(ld, st, inst, 30'($urandom), 30'($urandom_range(0, 15)), rd, $urandom,
                   waits, 5'd0, 32'd0, 1'b0, 0, 1'b0);
            predict(v.ld, v.st, v.inst, v.addr, v.rd, v.val, v.waits, e_rd, e_val, chk, e_stall);
            run_inst(v.ld, v.st, v.inst, v.pc, v.addr, v.rd, v.val, v.waits,
                     $sformatf("rnd%0d", k), o_rd, o_val, o_frd, o_fval, o_stall, o_err);
            judge($sformatf("rnd%0d", k), e_rd, e_val, chk, e_stall, exp_err,
                  o_rd, o_val, o_frd, o_fval, o_stall, o_err);
        end

        // Reset in the middle of an un-acked load, then the same load retried cleanly.
        load_in = 1'b1; store_in = 1'b0; inst_in = mem_inst(OP_LW, 11); pc_in = 30'h2a;
        addr_in = 30'h3; rd_in = 5'd11; rd_val_in = 32'h0; dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbusy_req", 64'(dmem_req), 64'd0);
        check("midbusy_stall", 64'(stall), 64'd0);
        check("midbusy_bus_err", 64'(bus_err), 64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_err = 1'b0;
        predict(1'b1, 1'b0, mem_inst(OP_LW, 11), 30'h3, 5'd11, 32'h0, 1, e_rd, e_val, chk, e_stall);
        run_inst(1'b1, 1'b0, mem_inst(OP_LW, 11), 30'h2a, 30'h3, 5'd11, 32'h0, 1,
                 "after_reset", o_rd, o_val, o_frd, o_fval, o_stall, o_err);
        judge("after_reset", e_rd, e_val, chk, e_stall, exp_err, o_rd, o_val, o_frd, o_fval,
              o_stall, o_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
